// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter, registered outputs; UART_TX_PARITY_EN adds an even-parity bit
module uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Active,
  output logic       o_TX_Serial,
  output logic       o_TX_Done
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_CLEANUP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic          serial_d, active_d, done_d;
  logic          cnt_done;

  // The bit timer saturates at CNT_LAST; every state that consumes a bit period restarts it.
  assign cnt_done = (cnt_q == CNT_LAST);

  // State, bit timer, shift data and the registered outputs.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      o_TX_Serial <= 1'b1;
      o_TX_Active <= 1'b0;
      o_TX_Done   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      o_TX_Serial <= serial_d;
      o_TX_Active <= active_d;
      o_TX_Done   <= done_d;
    end
  end

  // Next-state: walk start, data bits, optional parity, stop, then one cleanup cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (i_TX_DV) begin
          data_d  = i_TX_Byte;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_done) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_done) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (cnt_done) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (cnt_done) begin
          cnt_d   = '0;
          state_d = S_CLEANUP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CLEANUP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output next-values: the line lags the state by one cycle since outputs are registered.
  always_comb begin
    serial_d = 1'b1;
    active_d = o_TX_Active;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE:   active_d = i_TX_DV;
      S_START:  serial_d = 1'b0;
      S_DATA:   serial_d = data_q[idx_q];
`ifdef UART_TX_PARITY_EN
      S_PARITY: serial_d = ^data_q;
`endif
      S_STOP: begin
        if (cnt_done) begin
          active_d = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: begin
        serial_d = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx at CLKS_PER_BIT=4
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_dv = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       o_active, o_serial, o_done;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  int   starts[$];
  int   done_cnt = 0;
  int   exp_done = 0;
  int   n_starts;

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock    (clk),
    .i_Reset_n  (rst_n),
    .i_TX_DV    (tx_dv),
    .i_TX_Byte  (tx_byte),
    .o_TX_Active(o_active),
    .o_TX_Serial(o_serial),
    .o_TX_Done  (o_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: decode frames off the line and pop the scoreboard; check Active length and Done shape.
  int          cyc = 0;
  bit          in_frame = 1'b0;
  int          fpos = 0;
  int          act_run = 0;
  logic        prev_serial = 1'b1;
  logic        prev_act = 1'b0;
  logic        prev_done = 1'b0;
  logic [10:0] rx;
  exp_t        e;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      in_frame    = 1'b0;
      act_run     = 0;
      prev_serial = 1'b1;
      prev_act    = 1'b0;
      prev_done   = 1'b0;
    end else begin
      if (o_active) begin
        act_run++;
      end else if (prev_act) begin
        chk(act_run == FRAME, "active_len", act_run, FRAME);
        act_run = 0;
      end
      if (o_done) begin
        done_cnt++;
        chk(!o_active && prev_act, "done_edge", {o_active, prev_act}, 2'b01);
      end
      if (prev_done) chk(!o_done, "done_width", o_done, 0);

      if (!in_frame && prev_serial && !o_serial) begin
        in_frame = 1'b1;
        fpos     = 0;
        rx       = '0;
        starts.push_back(cyc);
      end
      if (in_frame) begin
        if (fpos % CPB == CPB / 2) begin
          rx[fpos / CPB] = o_serial;
          if (fpos / CPB == NB - 1) begin
            in_frame = 1'b0;
            chk(sb.size() != 0, "frame_expected", sb.size(), 1);
            if (sb.size() != 0) begin
              e = sb.pop_front();
              chk(rx[0] == 1'b0, "start_bit", rx[0], 0);
              chk(rx[8:1] == e.data, "data", rx[8:1], e.data);
`ifdef UART_TX_PARITY_EN
              chk(rx[9] == e.par, "parity", rx[9], e.par);
`endif
              chk(rx[NB-1] == 1'b1, "stop_bit", rx[NB-1], 1);
            end
          end
        end
        fpos++;
      end
      prev_serial = o_serial;
      prev_act    = o_active;
      prev_done   = o_done;
    end
  end

  task automatic send(input logic [7:0] b, input bit push, input logic par);
    exp_t x;
    @(posedge clk);
    #2;
    tx_dv   = 1'b1;
    tx_byte = b;
    if (push) begin
      x.data = b;
      x.par  = par;
      sb.push_back(x);
    end
    @(posedge clk);
    #2;
    tx_dv = 1'b0;
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_done) break;
    end
    chk(i < 200, "done_timeout", i, 200);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk(o_serial == 1'b1, "rst_serial", o_serial, 1);
    chk(o_active == 1'b0, "rst_active", o_active, 0);
    chk(o_done == 1'b0, "rst_done", o_done, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Async reset during a start bit: line must rise between edges.
    send(8'h81, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    chk(o_serial == 1'b0, "start_low", o_serial, 0);
    rst_n = 1'b0;
    #1;
    chk(o_serial == 1'b1, "async_serial", o_serial, 1);
    chk(o_active == 1'b0, "async_active", o_active, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 0xA5 with one-cycle DV-to-line-low latency.
    send(8'hA5, 1'b1, 1'b0);
    chk(o_serial == 1'b1, "latency_pre", o_serial, 1);
    @(posedge clk);
    #2;
    chk(o_serial == 1'b0, "latency_low", o_serial, 0);
    wait_done();
    exp_done++;

    // 0x00 then 0xFF, second DV in the first IDLE cycle after CLEANUP.
    repeat (2) @(posedge clk);
    send(8'h00, 1'b1, 1'b0);
    wait_done();
    exp_done++;
    @(posedge clk);
    #2;
    tx_dv   = 1'b1;
    tx_byte = 8'hFF;
    sb.push_back('{data: 8'hFF, par: 1'b0});
    @(posedge clk);
    #2 tx_dv = 1'b0;
    wait_done();
    exp_done++;
    n_starts = starts.size();
    chk(starts[n_starts-1] - starts[n_starts-2] == FRAME + 2, "b2b_spacing",
        starts[n_starts-1] - starts[n_starts-2], FRAME + 2);

    // DV during DATA and during CLEANUP ignored; byte change mid-frame has no effect.
    repeat (3) @(posedge clk);
    send(8'h5A, 1'b1, 1'b0);
    repeat (14) @(posedge clk);
    #2;
    tx_dv   = 1'b1;
    tx_byte = 8'hFF;
    @(posedge clk);
    #2;
    tx_dv   = 1'b0;
    tx_byte = 8'h00;
    wait_done();
    exp_done++;
    tx_dv   = 1'b1;
    tx_byte = 8'h11;
    @(posedge clk);
    #2 tx_dv = 1'b0;
    n_starts = starts.size();
    repeat (60) @(posedge clk);
    chk(starts.size() == n_starts, "no_extra_frame", starts.size(), n_starts);

    // Reset at data bit 3 of 0x3C, then a clean frame.
    send(8'h3C, 1'b0, 1'b0);
    repeat (18) @(posedge clk);
    #3;
    chk(o_active == 1'b1, "active_mid", o_active, 1);
    rst_n = 1'b0;
    #1;
    chk(o_serial == 1'b1, "abort_serial", o_serial, 1);
    chk(o_active == 1'b0, "abort_active", o_active, 0);
    chk(o_done == 1'b0, "abort_done", o_done, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    send(8'h3C, 1'b1, 1'b0);
    wait_done();
    exp_done++;

`ifdef UART_TX_PARITY_EN
    repeat (2) @(posedge clk);
    send(8'h07, 1'b1, 1'b1);
    wait_done();
    exp_done++;
    repeat (2) @(posedge clk);
    send(8'h03, 1'b1, 1'b0);
    wait_done();
    exp_done++;
`endif

    repeat (10) @(posedge clk);
    chk(sb.size() == 0, "sb_drain", sb.size(), 0);
    chk(done_cnt == exp_done, "done_count", done_cnt, exp_done);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Fixed-format asynchronous serial transmitter: 8 data bits, no parity, 1 stop bit, LSB first.
- Takes a byte through a single-cycle valid strobe and shifts it out on one line, with bit timing set by a clock-count parameter.
- Sits between the console/byte sequencer logic and the board UART TX pin (100 MHz system clock, 115200 baud by default).
- Reports busy and completion status so the upstream sequencer can pace bytes.

Parameters:
- CLKS_PER_BIT, 868, system clocks per serial bit (100_000_000/115200); legal range >= 2; bit counter width is $clog2(CLKS_PER_BIT)+1.

Ports:
- i_Clock  input  1  system clock, rising-edge active
- i_Reset_n  input  1  asynchronous active-low reset
- i_TX_DV  input  1  byte-valid strobe; sampled only in IDLE
- i_TX_Byte  input  8  byte to transmit; captured on the edge where i_TX_DV is accepted
- o_TX_Active  output  1  high while a frame (start through stop bit) is on the line
- o_TX_Serial  output  1  serial line; idles high
- o_TX_Done  output  1  one-cycle pulse at end of the stop bit

Behaviour:
- Reset (async, i_Reset_n=0): state=IDLE, o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, clock counter=0, bit index=0, data register=0. Outputs change immediately, not at the next edge.
- All outputs are registered.
- States: IDLE, START, DATA, STOP, CLEANUP.
- IDLE:
  - o_TX_Serial=1, o_TX_Done=0.
  - If i_TX_DV=1 on an edge: latch i_TX_Byte, set o_TX_Active=1, go to START.
  - The first start-bit cycle appears on the next cycle (1-cycle latency from DV to line low).
- START: o_TX_Serial=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - o_TX_Serial=data[index] for CLKS_PER_BIT cycles per bit, index 0..7.
  - After bit 7, go to STOP and reset the index to 0.
- STOP:
  - o_TX_Serial=1 for CLKS_PER_BIT cycles.
  - On the final edge: o_TX_Done=1 and o_TX_Active=0 (both visible the next cycle), go to CLEANUP.
- CLEANUP: one cycle; o_TX_Done returns to 0; line stays 1; go to IDLE.
- Frame length: 10*CLKS_PER_BIT cycles of o_TX_Active=1.
- Minimum DV-to-DV spacing: 10*CLKS_PER_BIT+2 cycles.
- i_TX_DV asserted outside IDLE (including CLEANUP) is ignored, not queued.
- i_TX_Byte changes after acceptance have no effect on the frame in flight.
- DV held continuously high: frames are sent back-to-back, re-sampling i_TX_Byte at each IDLE acceptance.
- Reset mid-frame: frame aborted; line returns high at once; no Done pulse.
- The counter compares against CLKS_PER_BIT-1 and never wraps beyond it.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 data bits) is inserted between bit 7 and the stop bit. It is an extra state lasting CLKS_PER_BIT cycles, so frame length becomes 11*CLKS_PER_BIT.
- Undefined: 8N1 exactly as above; no parity logic synthesized.

Test Plan:
- Reset value check, CLKS_PER_BIT=4: hold reset -> Serial=1, Active=0, Done=0; assert reset asynchronously between edges -> outputs change immediately.
- Send 0xA5 (CLKS_PER_BIT=4): DV pulse -> next cycle Serial=0 for 4 cycles, then 1,0,1,0,0,1,0,1 each for 4 cycles, then stop=1 for 4 cycles; Active high for 40 cycles; Done high for exactly 1 cycle right after.
- Send 0x00 then 0xFF, with DV re-asserted the first IDLE cycle after CLEANUP: line shows start + 8 zeros + stop, then start + 8 ones + stop; no extra gap beyond the CLEANUP and IDLE cycles.
- DV pulses during DATA and during CLEANUP -> ignored; only one frame sent; i_TX_Byte changed mid-frame does not alter the bits.
- Reset asserted at bit 3 of 0x3C -> Serial=1 and Active=0 immediately; no Done pulse; a following DV sends a clean full frame.
- UART_TX_PARITY_EN defined, byte 0x07 -> parity bit=1 after bit 7; frame is 44 cycles; with 0x03 the parity bit=0.
